ls148_irq_encoder: RTL and testbench

//  Registered 8-to-3 priority encoder with request latching and acknowledge handshake; the encode-side

---
 rtl/ls148_irq_encoder.sv | 96 +++++++++
 tb/tb_ls148_irq_encoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ls148_irq_encoder.sv
// Registered 8-to-3 priority encoder (SN74LS148 pin semantics) with request latching
// and an acknowledge handshake; the highest pending line is held until acknowledged.
module ls148_irq_encoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b1
) (
  input  logic       _CLK,
  input  logic       _RST,
  input  logic [7:0] _I,
  input  logic       _EI,
  input  logic       _ACK,
  output logic [2:0] _A,
  output logic       _GS,
  output logic       _EO,
  output logic [7:0] _PEND
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t                       state_q, state_d;
  logic [SYNC_STAGES-1:0][7:0]  sync_q;
  logic [7:0]                   s;
  logic [7:0]                   prev_q;
  logic [7:0]                   pending_q, pending_d;
  logic [7:0]                   rise, clr;
  logic                         ei_q, ack_q;
  logic [2:0]                   cur_q, cur_d, top;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = prev_q & ~s;

  // Ascending scan so the last hit, i.e. the highest set bit, wins.
  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pending_q[i]) top = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    clr     = '0;
    case (state_q)
      IDLE: begin
        if (!ei_q && (pending_q != '0)) begin
          cur_d   = top;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (ei_q) begin
          state_d = IDLE;
        end else if (!ack_q) begin
          clr     = 8'b1 << cur_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the line being cleared survives: set beats clear.
    pending_d = EDGE_MODE ? ((pending_q & ~clr) | rise) : ~s;
  end

  always_ff @(posedge _CLK) begin
    if (_RST) begin
      sync_q    <= '1;
      prev_q    <= '1;
      ei_q      <= 1'b1;
      ack_q     <= 1'b1;
      pending_q <= '0;
      state_q   <= IDLE;
      cur_q     <= '0;
    end else begin
      sync_q[0] <= _I;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q    <= s;
      ei_q      <= _EI;
      ack_q     <= _ACK;
      pending_q <= pending_d;
      state_q   <= state_d;
      cur_q     <= cur_d;
    end
  end

  assign _A    = (state_q == PRESENT) ? ~cur_q : 3'b111;
  assign _GS   = (state_q != PRESENT);
  assign _EO   = !(!ei_q && (state_q == IDLE) && (pending_q == '0));
  assign _PEND = pending_q;

endmodule

// File: tb/tb_ls148_irq_encoder.sv
// Bench for ls148_irq_encoder: edge-mode and level-mode instances on shared stimulus,
// directed scenarios plus random traffic, checked against a behavioural model.
module tb_ls148_irq_encoder;

  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_i = 8'h00;
  logic       ei = 1'b1;
  logic       ack = 1'b1;

  logic [2:0] a_e, a_l;
  logic       gs_e, gs_l, eo_e, eo_l;
  logic [7:0] pend_e, pend_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ls148_irq_encoder #(.SYNC_STAGES(SS), .EDGE_MODE(1'b1)) dut_e (
    ._CLK(clk), ._RST(rst), ._I(in_i), ._EI(ei), ._ACK(ack),
    ._A(a_e), ._GS(gs_e), ._EO(eo_e), ._PEND(pend_e)
  );

  ls148_irq_encoder #(.SYNC_STAGES(SS), .EDGE_MODE(1'b0)) dut_l (
    ._CLK(clk), ._RST(rst), ._I(in_i), ._EI(ei), ._ACK(ack),
    ._A(a_l), ._GS(gs_l), ._EO(eo_l), ._PEND(pend_l)
  );

  // Behavioural model: index 0 = edge mode, 1 = level mode.
  logic [7:0] mq[$];
  logic [7:0] m_prev;
  logic       m_ei, m_ack;
  logic [7:0] m_pend[2];
  bit         m_pres[2];
  int         m_code[2];

  function automatic int highest(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) if (v[b]) return b;
    return 0;
  endfunction

  task automatic model_edge();
    logic [7:0] s;
    logic [7:0] clr;
    if (rst) begin
      mq.delete();
      for (int k = 0; k < SS; k++) mq.push_back(8'hFF);
      m_prev = 8'hFF; m_ei = 1'b1; m_ack = 1'b1;
      for (int m = 0; m < 2; m++) begin
        m_pend[m] = 8'h00; m_pres[m] = 0; m_code[m] = 0;
      end
    end else begin
      s = mq[SS-1];
      for (int m = 0; m < 2; m++) begin
        clr = 8'h00;
        if (!m_pres[m]) begin
          if (!m_ei && m_pend[m] != 8'h00) begin
            m_code[m] = highest(m_pend[m]);
            m_pres[m] = 1;
          end
        end else if (m_ei) begin
          m_pres[m] = 0;
        end else if (!m_ack) begin
          clr = 8'h00;
          clr[m_code[m]] = 1'b1;
          m_pres[m] = 0;
        end
        if (m == 0) m_pend[m] = (m_pend[m] & ~clr) | (m_prev & ~s);
        else        m_pend[m] = ~s;
      end
      m_prev = s;
      mq.push_front(in_i);
      void'(mq.pop_back());
      m_ei  = ei;
      m_ack = ack;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [2:0] ea;
    for (int m = 0; m < 2; m++) begin
      ea = m_pres[m] ? ~3'(m_code[m]) : 3'b111;
      chk(m == 0 ? "e_A" : "l_A", {5'b0, (m == 0 ? a_e : a_l)}, {5'b0, ea});
      chk(m == 0 ? "e_GS" : "l_GS", {7'b0, (m == 0 ? gs_e : gs_l)}, {7'b0, !m_pres[m]});
      chk(m == 0 ? "e_EO" : "l_EO", {7'b0, (m == 0 ? eo_e : eo_l)},
          {7'b0, !(!m_ei && !m_pres[m] && m_pend[m] == 8'h00)});
      chk(m == 0 ? "e_PEND" : "l_PEND", (m == 0 ? pend_e : pend_l), m_pend[m]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic ack_pulse();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    tick();
  endtask

  task automatic wait_gs(input int m, input logic [2:0] exp_a, input string tag);
    int n = 0;
    while ((m == 0 ? gs_e : gs_l) !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, {5'b0, (m == 0 ? a_e : a_l)}, {5'b0, exp_a});
  endtask

  task automatic drain();
    in_i = 8'hFF; ei = 1'b0; ack = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 8; k++) begin
      if (gs_e == 1'b0 || gs_l == 1'b0 || pend_e != 8'h00 || pend_l != 8'h00) ack_pulse();
    end
  endtask

  initial begin
    // Reset held with all request lines low.
    rst = 1'b1; in_i = 8'h00; ei = 1'b0; ack = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_A", {5'b0, a_e}, 8'h07);
      chk("rst_GS", {7'b0, gs_e}, 8'h01);
      chk("rst_EO", {7'b0, eo_e}, 8'h01);
      chk("rst_PEND", pend_e, 8'h00);
      chk("rst_PEND_l", pend_l, 8'h00);
    end
    rst = 1'b0; in_i = 8'hFF;
    tick(); tick();
    chk("idle_EO", {7'b0, eo_e}, 8'h00);
    chk("idle_PEND", pend_e, 8'h00);

    // Single request latency on line 3.
    in_i = 8'hF7;
    tick(); tick();
    chk("t2_pend_e2", pend_e, 8'h00);
    tick();
    chk("t2_pend_e3", pend_e, 8'h08);
    chk("t2_gs_e3", {7'b0, gs_e}, 8'h01);
    tick();
    chk("t2_gs_e4", {7'b0, gs_e}, 8'h00);
    chk("t2_a_e4", {5'b0, a_e}, 8'h04);
    ack_pulse();
    chk("t2_gs_ack", {7'b0, gs_e}, 8'h01);
    chk("t2_a_ack", {5'b0, a_e}, 8'h07);
    chk("t2_pend_ack", pend_e, 8'h00);
    chk("t2_eo_ack", {7'b0, eo_e}, 8'h00);
    drain();

    // Priority: lines 2 and 6 together.
    in_i = ~8'h44;
    wait_gs(0, 3'b001, "t3_first");
    ack_pulse();
    chk("t3_gap_gs", {7'b0, gs_e}, 8'h01);
    tick();
    chk("t3_second", {5'b0, a_e}, 8'h05);
    ack_pulse();
    chk("t3_pend", pend_e, 8'h00);
    drain();

    // No pre-emption, then a set/clear collision on line 1.
    in_i = ~8'h02;
    wait_gs(0, 3'b110, "t4_first");
    in_i = ~8'h82;
    repeat (4) tick();
    chk("t4_hold", {5'b0, a_e}, 8'h06);
    in_i = ~8'h80;
    repeat (4) tick();
    in_i = ~8'h82;
    tick();
    ack = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    chk("t4_pend1", pend_e & 8'h02, 8'h02);
    chk("t4_gap_gs", {7'b0, gs_e}, 8'h01);
    tick();
    chk("t4_seven", {5'b0, a_e}, 8'h00);
    ack_pulse();
    tick();
    chk("t4_one_again", {5'b0, a_e}, 8'h06);
    ack_pulse();
    drain();

    // Enable gating and abort.
    ei = 1'b1;
    repeat (3) tick();
    in_i = ~8'h10;
    repeat (5) tick();
    chk("t5_gs_dis", {7'b0, gs_e}, 8'h01);
    chk("t5_eo_dis", {7'b0, eo_e}, 8'h01);
    chk("t5_pend_dis", pend_e, 8'h10);
    ei = 1'b0;
    wait_gs(0, 3'b011, "t5_first");
    ei = 1'b1;
    tick(); tick();
    chk("t5_abort_gs", {7'b0, gs_e}, 8'h01);
    chk("t5_abort_pend", pend_e, 8'h10);
    ei = 1'b0;
    wait_gs(0, 3'b011, "t5_again");
    ack_pulse();
    chk("t5_pend_clr", pend_e, 8'h00);
    drain();

    // Level mode: held line re-presents, released line drops.
    in_i = ~8'h20;
    wait_gs(1, 3'b010, "t6_first");
    ack_pulse();
    chk("t6_gap_gs", {7'b0, gs_l}, 8'h01);
    tick();
    chk("t6_again_gs", {7'b0, gs_l}, 8'h00);
    chk("t6_again_a", {5'b0, a_l}, 8'h02);
    in_i = 8'hFF;
    repeat (4) tick();
    ack_pulse();
    repeat (3) tick();
    chk("t6_pend", pend_l, 8'h00);
    chk("t6_gs", {7'b0, gs_l}, 8'h01);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) in_i[$urandom_range(7)] = ~in_i[$urandom_range(7)];
      if ($urandom_range(5) == 0) in_i = in_i ^ 8'($urandom);
      ei  = ($urandom_range(11) == 0);
      ack = ($urandom_range(2) != 0);
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
